// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared core constants and IF/ID action decode
package if_id_pkg;

  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  localparam logic [31:0] NOP_INST  = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_KILL,
    ACT_CAPTURE
  } act_e;

  // kill_any folds the live branch kill together with a remembered one
  function automatic act_e next_action(input logic flush, input logic [5:0] stall,
                                       input logic kill_any);
    if (flush)                return ACT_FLUSH;
    else if (stall[STALL_ID]) return ACT_HOLD;
    else if (stall[STALL_IF]) return ACT_BUBBLE;
    else if (kill_any)        return ACT_KILL;
    else                      return ACT_CAPTURE;
  endfunction

endpackage

// File: rtl/if_id_if.sv
// rtl/if_id_if.sv - fetch/control to decode bundle for the IF/ID register
interface if_id_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = 16
);
  logic [5:0]        stall_i;
  logic              flush_i;
  logic              branch_kill_i;
  logic [ADDR_W-1:0] if_inst_addr_i;
  logic [INST_W-1:0] if_inst_i;
  logic [ADDR_W-1:0] id_inst_addr_o;
  logic [INST_W-1:0] id_inst_o;
  logic              id_valid_o;
  logic [CNT_W-1:0]  bubble_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output stall_i, flush_i, branch_kill_i, if_inst_addr_i, if_inst_i,
    input  id_inst_addr_o, id_inst_o, id_valid_o, bubble_cnt_o, flush_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, branch_kill_i, if_inst_addr_i, if_inst_i,
    output id_inst_addr_o, id_inst_o, id_valid_o, bubble_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/if_id_sat_counter.sv
// rtl/if_id_sat_counter.sv - unsigned counter that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if_id.sv
// rtl/if_id.sv - IF/ID pipeline register with stall, flush, branch kill and perf counters
module if_id
  import if_id_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = if_id_pkg::NOP_INST,
  parameter int                CNT_W    = 16
) (
  input logic    clk,
  input logic    rst,
  if_id_if.slave bus
);

  logic [ADDR_W-1:0] addr_q;
  logic [INST_W-1:0] inst_q;
  logic              valid_q;
  logic              kill_pending;
  act_e              act;
  logic              bubble_inc;
  logic              flush_inc;
  logic              unused_stall;

  assign unused_stall = ^{bus.stall_i[5:3], bus.stall_i[0]};

  assign act = next_action(bus.flush_i, bus.stall_i, bus.branch_kill_i | kill_pending);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= ADDR_W'(ZERO_WORD);
      inst_q       <= NOP_INST;
      valid_q      <= 1'b0;
      kill_pending <= 1'b0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          addr_q       <= ADDR_W'(ZERO_WORD);
          inst_q       <= NOP_INST;
          valid_q      <= 1'b0;
          kill_pending <= 1'b0;
        end
        ACT_HOLD: begin
          // wrong-path instruction stays parked in IF; squash it when it moves
          kill_pending <= kill_pending | bus.branch_kill_i;
        end
        ACT_BUBBLE: begin
          addr_q       <= ADDR_W'(ZERO_WORD);
          inst_q       <= NOP_INST;
          valid_q      <= 1'b0;
          kill_pending <= kill_pending | bus.branch_kill_i;
        end
        ACT_KILL: begin
          addr_q       <= bus.if_inst_addr_i;
          inst_q       <= NOP_INST;
          valid_q      <= 1'b0;
          kill_pending <= 1'b0;
        end
        default: begin
          addr_q  <= bus.if_inst_addr_i;
          inst_q  <= bus.if_inst_i;
          valid_q <= 1'b1;
        end
      endcase
    end
  end

  assign bubble_inc = (act == ACT_BUBBLE) || (act == ACT_KILL);
  assign flush_inc  = (act == ACT_FLUSH);

  sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (bus.bubble_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (bus.flush_cnt_o)
  );

  assign bus.id_inst_addr_o = addr_q;
  assign bus.id_inst_o      = inst_q;
  assign bus.id_valid_o     = valid_q;

endmodule

// File: tb/tb_if_id.sv
// tb/tb_if_id.sv - table, directed and random checks of if_id against a behavioural model
module tb_if_id;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_id_if #(.ADDR_W(32), .INST_W(32), .CNT_W(16)) bus ();
  if_id_if #(.ADDR_W(32), .INST_W(32), .CNT_W(2))  sbus ();

  if_id #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  if_id #(.CNT_W(2))  u_sat (.clk(clk), .rst(rst), .bus(sbus));

  assign sbus.stall_i        = bus.stall_i;
  assign sbus.flush_i        = bus.flush_i;
  assign sbus.branch_kill_i  = bus.branch_kill_i;
  assign sbus.if_inst_addr_i = bus.if_inst_addr_i;
  assign sbus.if_inst_i      = bus.if_inst_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_addr, m_inst;
  logic        m_valid, m_kp;
  int          m_bub, m_flu;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // Spec rules applied to the values present at the clock edge
  task automatic model_edge();
    if (rst) begin
      m_addr = 0; m_inst = 0; m_valid = 0; m_kp = 0; m_bub = 0; m_flu = 0;
    end else if (bus.flush_i) begin
      m_addr = 0; m_inst = 0; m_valid = 0; m_kp = 0; m_flu++;
    end else if (bus.stall_i[2]) begin
      if (bus.branch_kill_i) m_kp = 1;
    end else if (bus.stall_i[1]) begin
      m_addr = 0; m_inst = 0; m_valid = 0; m_bub++;
      if (bus.branch_kill_i) m_kp = 1;
    end else if (bus.branch_kill_i || m_kp) begin
      m_addr = bus.if_inst_addr_i; m_inst = 0; m_valid = 0; m_kp = 0; m_bub++;
    end else begin
      m_addr = bus.if_inst_addr_i; m_inst = bus.if_inst_i; m_valid = 1;
    end
  endtask

  task automatic step(input logic [5:0] st, input logic fl, input logic kl,
                      input logic [31:0] a, input logic [31:0] i);
    bus.stall_i = st; bus.flush_i = fl; bus.branch_kill_i = kl;
    bus.if_inst_addr_i = a; bus.if_inst_i = i;
    @(posedge clk);
    model_edge();
    #1;
    check("model_addr",  bus.id_inst_addr_o, m_addr);
    check("model_inst",  bus.id_inst_o, m_inst);
    check("model_valid", bus.id_valid_o, m_valid);
    check("model_bub",   bus.bubble_cnt_o, sat(m_bub, 16));
    check("model_flu",   bus.flush_cnt_o, sat(m_flu, 16));
    check("sat_bub",     sbus.bubble_cnt_o, sat(m_bub, 2));
    check("sat_flu",     sbus.flush_cnt_o, sat(m_flu, 2));
  endtask

  task automatic expect_out(input string name, input logic [31:0] a, input logic [31:0] i,
                            input logic v, input int bub, input int flu);
    check({name, "_addr"},  bus.id_inst_addr_o, a);
    check({name, "_inst"},  bus.id_inst_o, i);
    check({name, "_valid"}, bus.id_valid_o, v);
    check({name, "_bub"},   bus.bubble_cnt_o, bub);
    check({name, "_flu"},   bus.flush_cnt_o, flu);
  endtask

  typedef struct {
    logic [5:0]  st;
    logic        fl, kl;
    logic [31:0] a, i;
    logic [31:0] ea, ei;
    logic        ev;
    int          eb;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{6'b000000, 0, 0, 32'h4,  32'h3401_1100, 32'h4,  32'h3401_1100, 1, 0};
    tbl[1] = '{6'b000110, 0, 0, 32'h8,  32'h1111_1111, 32'h4,  32'h3401_1100, 1, 0};
    tbl[2] = '{6'b000110, 0, 0, 32'hC,  32'h2222_2222, 32'h4,  32'h3401_1100, 1, 0};
    tbl[3] = '{6'b000110, 0, 0, 32'h8,  32'h1111_1111, 32'h4,  32'h3401_1100, 1, 0};
    tbl[4] = '{6'b000000, 0, 0, 32'h8,  32'h0000_0013, 32'h8,  32'h0000_0013, 1, 0};
    tbl[5] = '{6'b000010, 0, 0, 32'hC,  32'hAAAA_AAAA, 32'h0,  32'h0,         0, 1};
    tbl[6] = '{6'b000010, 0, 0, 32'hC,  32'hAAAA_AAAA, 32'h0,  32'h0,         0, 2};
    tbl[7] = '{6'b000000, 0, 1, 32'h10, 32'h2002_0001, 32'h10, 32'h0,         0, 3};
    tbl[8] = '{6'b000000, 0, 0, 32'h14, 32'h0000_5555, 32'h14, 32'h0000_5555, 1, 3};

    rst = 1'b1;
    step(6'b0, 0, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    expect_out("reset", 32'h0, 32'h0, 0, 0, 0);
    step(6'b0, 0, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    expect_out("reset2", 32'h0, 32'h0, 0, 0, 0);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) begin
      step(tbl[k].st, tbl[k].fl, tbl[k].kl, tbl[k].a, tbl[k].i);
      check($sformatf("tbl%0d_addr", k),  bus.id_inst_addr_o, tbl[k].ea);
      check($sformatf("tbl%0d_inst", k),  bus.id_inst_o, tbl[k].ei);
      check($sformatf("tbl%0d_valid", k), bus.id_valid_o, tbl[k].ev);
      check($sformatf("tbl%0d_bub", k),   bus.bubble_cnt_o, tbl[k].eb);
    end

    // kill while ID stalled: first transfer after release is squashed
    step(6'b000110, 0, 1, 32'h18, 32'h66);
    expect_out("kill_hold", 32'h14, 32'h5555, 1, 3, 0);
    step(6'b000110, 0, 0, 32'h18, 32'h66);
    step(6'b000000, 0, 0, 32'h18, 32'h66);
    expect_out("kill_rel", 32'h18, 32'h0, 0, 4, 0);
    step(6'b000000, 0, 0, 32'h1C, 32'h77);
    expect_out("kill_next", 32'h1C, 32'h77, 1, 4, 0);

    // kill during IF-only stall: bubble now, squash on transfer
    step(6'b000010, 0, 1, 32'h20, 32'h88);
    expect_out("kill_ifst", 32'h0, 32'h0, 0, 5, 0);
    step(6'b000000, 0, 0, 32'h20, 32'h88);
    expect_out("kill_ifrel", 32'h20, 32'h0, 0, 6, 0);

    // flush beats stall and kill, and clears a pending kill
    step(6'b000110, 0, 1, 32'h24, 32'h99);
    step(6'b000110, 1, 1, 32'h24, 32'h99);
    expect_out("flush_win", 32'h0, 32'h0, 0, 6, 1);
    step(6'b000000, 0, 0, 32'h24, 32'h99);
    expect_out("flush_kpclr", 32'h24, 32'h99, 1, 6, 1);

    // reset drops a pending kill
    step(6'b000110, 0, 1, 32'h28, 32'hAB);
    rst = 1'b1;
    step(6'b000110, 0, 0, 32'h28, 32'hAB);
    expect_out("rst_mid", 32'h0, 32'h0, 0, 0, 0);
    rst = 1'b0;
    step(6'b000000, 0, 0, 32'h28, 32'hAB);
    expect_out("rst_kpclr", 32'h28, 32'hAB, 1, 0, 0);

    // 2-bit flush counter saturates at 3
    for (int k = 1; k <= 5; k++) begin
      step(6'b000000, 1, 0, 32'h30, 32'h1);
      check($sformatf("sat_flush%0d", k), sbus.flush_cnt_o, (k > 3) ? 3 : k);
      check($sformatf("wide_flush%0d", k), bus.flush_cnt_o, k);
    end

    for (int k = 0; k < 400; k++) begin
      logic [5:0] st;
      st = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'b0;
      rst = ($urandom_range(0, 99) == 0);
      step(st, $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0, $urandom, $urandom);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
